// File: rtl/sipo_cfg_loader_pkg.sv
// rtl/sipo_cfg_loader_pkg.sv - state encodings and defaults for the SIPO config loader
package sipo_cfg_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SHIFT = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  localparam int DATA_W_DEF  = 25;
  localparam int CLR_CYC_DEF = 2;
  localparam int TIMEOUT_DEF = 4;

  // One counter serves the clear, shift and wait phases, so size it for the longest.
  function automatic int cnt_width(input int shift_len, input int clr_len, input int wait_len);
    int m;
    m = (shift_len > clr_len) ? shift_len : clr_len;
    m = (m > wait_len) ? m : wait_len;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sipo_cfg_shreg.sv
// rtl/sipo_cfg_shreg.sv - loadable shadow register that shifts its config word out MSB first
module sipo_cfg_shreg
  import sipo_cfg_loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic              msb
);

  logic [DATA_W-1:0] shadow_q;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
    end else if (load) begin
      shadow_q <= din;
    end else if (shift) begin
      shadow_q <= {shadow_q[DATA_W-2:0], 1'b0};
    end
  end

  assign msb = shadow_q[DATA_W-1];

endmodule

// File: rtl/sipo_cfg_loader.sv
// rtl/sipo_cfg_loader.sv - sequences clear, marker+config shift and finish check of the SIPO chain
module sipo_cfg_loader
  import sipo_cfg_loader_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CLR_CYC = CLR_CYC_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              sipo_finished,
  output logic              sipo_in,
  output logic              sipo_en,
  output logic              sipo_rst,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = cnt_width(DATA_W + 1, CLR_CYC, TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_CLR   = CNT_W'(CLR_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_SHIFT = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_WAIT  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load, shift, aborting, shadow_msb;
  logic             sipo_in_d, sipo_en_d, sipo_rst_d, busy_d, done_d, error_d;

  sipo_cfg_shreg #(
    .DATA_W(DATA_W)
  ) u_shreg (
    .clock(clock),
    .rst  (rst),
    .load (load),
    .shift(shift),
    .din  (cfg_data),
    .msb  (shadow_msb)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    shift    = 1'b0;
    aborting = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start && !abort) begin
          load    = 1'b1;
          cnt_d   = CNT_CLR;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_SHIFT;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_SHIFT: begin
        // The marker goes out on the first SHIFT cycle; the shadow only moves after it.
        if (cnt_q == '0) begin
          cnt_d   = CNT_WAIT;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          shift = 1'b1;
        end
      end
      S_WAIT: begin
        if (sipo_finished) begin
          state_d = S_DONE;
        end else if (cnt_q == '0) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && state_q != S_IDLE) begin
      aborting = 1'b1;
      load     = 1'b0;
      shift    = 1'b0;
      cnt_d    = '0;
      state_d  = S_IDLE;
    end

    sipo_rst_d = aborting || (state_d == S_CLEAR);
    sipo_en_d  = (state_d == S_SHIFT);
    sipo_in_d  = ((state_q == S_CLEAR) && (state_d == S_SHIFT)) || (shift && shadow_msb);
    busy_d     = (state_d == S_CLEAR) || (state_d == S_SHIFT) || (state_d == S_WAIT);
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERROR);
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sipo_in  <= 1'b0;
      sipo_en  <= 1'b0;
      sipo_rst <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sipo_in  <= sipo_in_d;
      sipo_en  <= sipo_en_d;
      sipo_rst <= sipo_rst_d;
      busy     <= busy_d;
      done     <= done_d;
      error    <= error_d;
    end
  end

endmodule

// File: tb/tb_sipo_cfg_loader.sv
// tb/tb_sipo_cfg_loader.sv - self-checking bench for sipo_cfg_loader with a behavioural chain
module tb_sipo_cfg_loader;

  localparam int W   = 25;
  localparam int CLR = 2;
  localparam int TO  = 4;

  logic         clock = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] cfg_data = '0;
  logic         sipo_finished;
  logic         sipo_in, sipo_en, sipo_rst, busy, done, error;

  logic         chain_ok = 1'b1;
  logic         force_fin = 1'b0;
  logic [W:0]   chain = '0;
  int           en_total = 0;

  int vectors = 0;
  int miscompares = 0;

  sipo_cfg_loader dut (
    .clock        (clock),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .cfg_data     (cfg_data),
    .sipo_finished(sipo_finished),
    .sipo_in      (sipo_in),
    .sipo_en      (sipo_en),
    .sipo_rst     (sipo_rst),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 clock = ~clock;

  // Chain: marker reaches the far end after W+1 shifts and raises finished.
  always @(posedge clock or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      if (sipo_rst)     chain <= '0;
      else if (sipo_en) chain <= {chain[W-1:0], sipo_in};
      if (sipo_en) en_total <= en_total + 1;
    end
  end
  assign sipo_finished = force_fin | (chain_ok & chain[W]);

  // Timeline model: k counts cycles since the accepted start.
  typedef enum {M_IDLE, M_LOAD, M_DONE, M_ERR} mmode_t;
  mmode_t     m_mode = M_IDLE;
  int         m_k = 0;
  logic [W:0] m_frame = '0;
  logic       m_abort_pulse = 1'b0;

  always @(posedge clock or posedge rst) begin
    if (rst) begin
      m_mode        <= M_IDLE;
      m_k           <= 0;
      m_frame       <= '0;
      m_abort_pulse <= 1'b0;
    end else begin
      m_abort_pulse <= 1'b0;
      if (abort && m_mode != M_IDLE) begin
        m_mode        <= M_IDLE;
        m_abort_pulse <= 1'b1;
      end else if (m_mode == M_LOAD) begin
        if (m_k >= CLR + W + 1) begin
          if (sipo_finished)                 m_mode <= M_DONE;
          else if (m_k - (CLR + W + 1) == TO - 1) m_mode <= M_ERR;
          else                               m_k <= m_k + 1;
        end else begin
          m_k <= m_k + 1;
        end
      end else if (start && !abort) begin
        m_mode  <= M_LOAD;
        m_k     <= 0;
        m_frame <= {1'b1, cfg_data};
      end
    end
  end

  function automatic logic [5:0] model_out();
    logic [5:0] e;  // {sipo_in, sipo_en, sipo_rst, busy, done, error}
    e = '0;
    if (m_abort_pulse) begin
      e[3] = 1'b1;
    end else begin
      case (m_mode)
        M_LOAD: begin
          e[2] = 1'b1;
          if (m_k < CLR) begin
            e[3] = 1'b1;
          end else if (m_k < CLR + W + 1) begin
            e[4] = 1'b1;
            e[5] = m_frame[W - (m_k - CLR)];
          end
        end
        M_DONE:  e[1] = 1'b1;
        M_ERR:   e[0] = 1'b1;
        default: e = '0;
      endcase
    end
    return e;
  endfunction

  task automatic tick();
    logic [5:0] act, exp_v;
    @(negedge clock);
    act   = {sipo_in, sipo_en, sipo_rst, busy, done, error};
    exp_v = model_out();
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL cycle_outputs t=%0t got=%b expected=%b", $time, act, exp_v);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp_v);
    end
  endtask

  task automatic do_start(input logic [W-1:0] cfg);
    start    = 1'b1;
    cfg_data = cfg;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_flag(input logic want_err, output int lat);
    lat = 0;
    while (!(want_err ? error : done) && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  int lat, base;

  initial begin
    ticks(2);
    chk("reset_outputs", {26'd0, sipo_in, sipo_en, sipo_rst, busy, done, error}, 32'd0);
    rst = 1'b0;
    ticks(2);

    // Nominal load
    base = en_total;
    do_start(25'h1A5_5A5A);
    wait_flag(1'b0, lat);
    chk("nominal_latency", lat, 29);
    chk("nominal_shift_count", en_total - base, 26);
    chk("nominal_frame", {6'd0, chain}, 32'h3A5_5A5A);
    ticks(3);
    chk("done_held", {31'd0, done}, 32'd1);

    // Reload from DONE with all-zero config
    do_start(25'h0);
    chk("done_drops_on_reload", {31'd0, done}, 32'd0);
    wait_flag(1'b0, lat);
    chk("zero_latency", lat, 29);
    chk("zero_frame", {6'd0, chain}, 32'h200_0000);

    // Broken chain: timeout to sticky error, then clean retry
    chain_ok = 1'b0;
    do_start(25'h0F0_F0F0);
    wait_flag(1'b1, lat);
    chk("error_latency", lat, 32);
    ticks(5);
    chk("error_sticky", {31'd0, error}, 32'd1);
    chain_ok = 1'b1;
    do_start(25'h155_5555);
    wait_flag(1'b0, lat);
    chk("retry_latency", lat, 29);
    chk("retry_error_clear", {31'd0, error}, 32'd0);
    chk("retry_frame", {6'd0, chain}, 32'h355_5555);

    // Abort during the tenth shift
    base = en_total;
    do_start(25'h1FF_FFFF);
    ticks(11);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_rst_pulse", {28'd0, sipo_rst, busy, done, error}, 32'h8);
    chk("abort_shift_count", en_total - base, 10);
    tick();
    chk("abort_rst_one_cycle", {31'd0, sipo_rst}, 32'd0);

    // start && abort together in IDLE
    start    = 1'b1;
    abort    = 1'b1;
    cfg_data = 25'h123_4567;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", {30'd0, busy, sipo_rst}, 32'd0);
    tick();

    // start while busy is ignored
    base = en_total;
    do_start(25'h123_4567);
    ticks(8);
    start    = 1'b1;
    cfg_data = 25'h0AB_CDEF;
    tick();
    start = 1'b0;
    wait_flag(1'b0, lat);
    chk("busy_start_latency", lat + 9, 29);
    chk("busy_start_shifts", en_total - base, 26);
    chk("busy_start_frame", {6'd0, chain}, 32'h323_4567);

    // Abort in DONE
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_done", {29'd0, sipo_rst, done, busy}, 32'h4);
    tick();

    // Async reset mid-shift
    do_start(25'h1AB_CDEF);
    ticks(12);
    #2 rst = 1'b1;
    #1 chk("async_rst_outputs", {26'd0, sipo_in, sipo_en, sipo_rst, busy, done, error}, 32'd0);
    tick();
    rst = 1'b0;
    ticks(2);
    chk("post_rst_idle", {31'd0, busy}, 32'd0);
    do_start(25'h0C3_C3C3);
    wait_flag(1'b0, lat);
    chk("post_rst_latency", lat, 29);
    chk("post_rst_frame", {6'd0, chain}, 32'h2C3_C3C3);

    // Spurious finished during CLEAR/SHIFT
    base      = en_total;
    force_fin = 1'b1;
    do_start(25'h1F0_F0F0);
    ticks(15);
    force_fin = 1'b0;
    wait_flag(1'b0, lat);
    chk("spurious_latency", lat + 15, 29);
    chk("spurious_shifts", en_total - base, 26);
    chk("spurious_frame", {6'd0, chain}, 32'h3F0_F0F0);
    ticks(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
